// File: rtl/dac_instr_queue.sv
// Per-channel latest-value buffer feeding the DAC serial controller.
// Pending channels are issued one word per controller transaction, round-robin.
module dac_instr_queue #(
    parameter int W_CHAN = 5,
    parameter int N_CHAN = 8,
    parameter int W_DATA = 16,
    parameter int W_OVR  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dv_in,
    input  logic [W_CHAN-1:0] chan_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic              dac_rdy_in,
    output logic              dv_out,
    output logic [W_CHAN-1:0] chan_out,
    output logic [W_DATA-1:0] data_out,
    output logic [W_OVR-1:0]  ovr_count_out
);

    localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    // Handshake: dv_out is a one-cycle strobe issued only from IDLE while
    // dac_rdy_in is high; the controller must drop dac_rdy_in (seen in
    // WAIT_LOW) before another word may be issued.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_CHAN-1:0]  pend_q, pend_d;
    logic [W_DATA-1:0]  data_buf_q [N_CHAN];
    logic [W_IDX-1:0]   rr_ptr_q, rr_ptr_d;
    logic               dv_out_q, dv_out_d;
    logic [W_CHAN-1:0]  chan_out_q, chan_out_d;
    logic [W_DATA-1:0]  data_out_q, data_out_d;
    logic [W_OVR-1:0]   ovr_q, ovr_d;

    logic [W_IDX-1:0]   sel;
    logic [W_IDX-1:0]   cand;
    logic [W_IDX-1:0]   wr_idx;
    logic               found;
    logic               any;
    logic               wr_ok;
    logic               issue;
    logic               ovr_hit;

    // Round-robin search starting at rr_ptr_q
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            cand = W_IDX'((int'(rr_ptr_q) + i) % N_CHAN);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign any     = |pend_q;
    assign wr_idx  = chan_in[W_IDX-1:0];
    assign wr_ok   = dv_in && (int'(chan_in) < N_CHAN);
    assign issue   = (state_q == IDLE) && dac_rdy_in && any;
    // A write colliding with the issue of the same channel is not an overwrite
    assign ovr_hit = wr_ok && pend_q[wr_idx] && !(issue && (sel == wr_idx));

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        rr_ptr_d   = rr_ptr_q;
        dv_out_d   = 1'b0;
        chan_out_d = chan_out_q;
        data_out_d = data_out_q;
        ovr_d      = ovr_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    dv_out_d    = 1'b1;
                    chan_out_d  = W_CHAN'(sel);
                    data_out_d  = data_buf_q[sel];
                    pend_d[sel] = 1'b0;
                    rr_ptr_d    = (int'(sel) == N_CHAN - 1) ? '0 : sel + 1'b1;
                    state_d     = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!dac_rdy_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the issue clear so a same-edge write keeps the channel pending
        if (wr_ok) begin
            pend_d[wr_idx] = 1'b1;
        end

        if (ovr_hit && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            dv_out_q   <= dv_out_d;
            chan_out_q <= chan_out_d;
            data_out_q <= data_out_d;
            ovr_q      <= ovr_d;
        end
    end

    // Data storage is deliberately left out of reset
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            data_buf_q[wr_idx] <= data_in;
        end
    end

    assign dv_out        = dv_out_q;
    assign chan_out      = chan_out_q;
    assign data_out      = data_out_q;
    assign ovr_count_out = ovr_q;

endmodule
